// File: rtl/cache_line_arbiter_if.sv
// Bundle of the instruction-side, data-side and memory-side line ports of the arbiter.
// The master view is the arbiter itself; the slave view is the caches plus memory.
interface cache_line_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between I-cache and D-cache.
// One transaction in flight; all outputs come straight from registers.
module cache_line_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_line_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_last_grant;
    logic              r_is_write;
    logic              r_i_resp;
    logic              r_d_resp;
    logic              r_m_read;
    logic              r_m_write;
    logic [ADDR_W-1:0] r_m_addr;
    logic [LINE_W-1:0] r_m_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;

    logic              w_d_req;
    logic              w_win_d;

    assign w_d_req = bus.d_read | bus.d_write;

    always_comb begin
        w_state_next = r_state;
        w_win_d      = GRANT_I;
        case (r_state)
            IDLE: begin
                // On a tie the side that did not win last time gets the port.
                if (bus.i_read && w_d_req) begin
                    w_win_d = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
                end else begin
                    w_win_d = w_d_req;
                end
                if (bus.i_read || w_d_req) begin
                    w_state_next = w_win_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus.m_resp) begin
                    w_state_next = DONE;
                end
            end
            BUSY_D: begin
                if (bus.m_resp) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            r_is_write   <= 1'b0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_m_read     <= 1'b0;
            r_m_write    <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_state_next != IDLE) begin
                        r_last_grant <= w_win_d;
                        if (w_win_d) begin
                            // d_write wins over d_read when both are (illegally) set.
                            r_m_addr   <= bus.d_addr;
                            r_m_wdata  <= bus.d_wdata;
                            r_is_write <= bus.d_write;
                            r_m_write  <= bus.d_write;
                            r_m_read   <= ~bus.d_write;
                        end else begin
                            r_m_addr   <= bus.i_addr;
                            r_is_write <= 1'b0;
                            r_m_write  <= 1'b0;
                            r_m_read   <= 1'b1;
                        end
                    end
                end
                BUSY_I: begin
                    if (bus.m_resp) begin
                        r_i_rdata <= bus.m_rdata;
                        r_i_resp  <= 1'b1;
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (bus.m_resp) begin
                        if (!r_is_write) begin
                            r_d_rdata <= bus.m_rdata;
                        end
                        r_d_resp  <= 1'b1;
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.i_rdata = r_i_rdata;
    assign bus.i_resp  = r_i_resp;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_resp  = r_d_resp;
    assign bus.m_read  = r_m_read;
    assign bus.m_write = r_m_write;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench for cache_line_arbiter: scripted memory responder plus response scoreboard.
module tb_cache_line_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam logic [LINE_W-1:0] GARBAGE = {8{32'hDEADBEEF}};

    typedef struct {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] line;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_line_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    cache_line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic              i_read_v  = 1'b0;
    logic [ADDR_W-1:0] i_addr_v  = '0;
    logic              d_read_v  = 1'b0;
    logic              d_write_v = 1'b0;
    logic [ADDR_W-1:0] d_addr_v  = '0;
    logic [LINE_W-1:0] d_wdata_v = '0;
    logic              auto_resp = 1'b0;
    logic              spur_resp = 1'b0;
    logic [LINE_W-1:0] resp_line = '0;
    logic              mem_en    = 1'b1;
    int                mem_lat   = 1;

    assign bus.i_read  = i_read_v;
    assign bus.i_addr  = i_addr_v;
    assign bus.d_read  = d_read_v;
    assign bus.d_write = d_write_v;
    assign bus.d_addr  = d_addr_v;
    assign bus.d_wdata = d_wdata_v;
    assign bus.m_resp  = auto_resp | spur_resp;
    assign bus.m_rdata = auto_resp ? resp_line : GARBAGE;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    logic [LINE_W-1:0] model_i = '0;
    logic [LINE_W-1:0] model_d = '0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic exp_i(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line);
        mem_q.push_back('{is_write: 1'b0, addr: addr, wdata: '0, rdata: line});
        resp_q.push_back('{is_d: 1'b0, line: line});
        model_i = line;
    endtask

    task automatic exp_d_rd(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line);
        mem_q.push_back('{is_write: 1'b0, addr: addr, wdata: '0, rdata: line});
        resp_q.push_back('{is_d: 1'b1, line: line});
        model_d = line;
    endtask

    task automatic exp_d_wr(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
        mem_q.push_back('{is_write: 1'b1, addr: addr, wdata: wdata, rdata: GARBAGE});
        resp_q.push_back('{is_d: 1'b1, line: model_d});
    endtask

    // Memory responder: answers after mem_lat strobe cycles and checks the request it serves.
    initial begin
        int cnt;
        mem_exp_t e;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (auto_resp) begin
                auto_resp = 1'b0;
                cnt = 0;
            end else if (mem_en && (bus.m_read || bus.m_write)) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected", 1, 0);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_addr", LINE_W'(bus.m_addr), LINE_W'(e.addr));
                        check("mem_write", LINE_W'(bus.m_write), LINE_W'(e.is_write));
                        check("mem_read", LINE_W'(bus.m_read), LINE_W'(!e.is_write));
                        if (e.is_write) check("mem_wdata", bus.m_wdata, e.wdata);
                        $display("mem %s addr=%h", e.is_write ? "WR" : "RD", bus.m_addr);
                        resp_line = e.rdata;
                        auto_resp = 1'b1;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Response monitor: every resp pulse must match the next scoreboard entry.
    initial begin
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp) begin
                if (bus.i_resp && bus.d_resp) check("resp_both", 1, 0);
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", LINE_W'({bus.i_resp, bus.d_resp}), 0);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_side", LINE_W'(bus.d_resp), LINE_W'(r.is_d));
                    check("resp_rdata", r.is_d ? bus.d_rdata : bus.i_rdata, r.line);
                    $display("resp side=%s rdata=%h", bus.d_resp ? "D" : "I",
                             bus.d_resp ? bus.d_rdata : bus.i_rdata);
                end
            end
        end
    end

    task automatic run_done(input int budget);
        int n;
        n = 0;
        while ((i_read_v || d_read_v || d_write_v) && n < budget) begin
            @(negedge clk);
            if (bus.i_resp) i_read_v = 1'b0;
            if (bus.d_resp) begin
                d_read_v  = 1'b0;
                d_write_v = 1'b0;
            end
            n++;
        end
        if (n >= budget) begin
            check("timeout", 1, 0);
            i_read_v = 1'b0; d_read_v = 1'b0; d_write_v = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_i_resp"},  LINE_W'(bus.i_resp), 0);
        check({tag, "_d_resp"},  LINE_W'(bus.d_resp), 0);
        check({tag, "_m_read"},  LINE_W'(bus.m_read), 0);
        check({tag, "_m_write"}, LINE_W'(bus.m_write), 0);
        check({tag, "_m_addr"},  LINE_W'(bus.m_addr), 0);
        check({tag, "_m_wdata"}, bus.m_wdata, 0);
        check({tag, "_i_rdata"}, bus.i_rdata, 0);
        check({tag, "_d_rdata"}, bus.d_rdata, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_i = '0;
        model_d = '0;
    endtask

    initial begin
        int cnt;
        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single I read, memory answers at the 3rd strobe cycle
        mem_lat = 3;
        exp_i(32'h0000_0060, {32{8'hA5}});
        i_addr_v = 32'h0000_0060;
        i_read_v = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.m_read) cnt++;
            if (bus.i_resp) begin
                check("done_m_read", LINE_W'(bus.m_read), 0);
                i_read_v = 1'b0;
                break;
            end
        end
        check("i_strobe_cycles", LINE_W'(cnt), 3);
        repeat (3) @(negedge clk);

        // D read to make d_rdata nonzero, then D write-back leaves it untouched
        mem_lat = 2;
        exp_d_rd(32'h0400_0040, {16{16'h5AC3}});
        d_addr_v = 32'h0400_0040; d_read_v = 1'b1;
        run_done(50);
        mem_lat = 1;
        exp_d_wr(32'h1000_0020, {8{32'h12345678}});
        d_addr_v = 32'h1000_0020; d_wdata_v = {8{32'h12345678}}; d_write_v = 1'b1;
        run_done(50);
        check("wb_d_rdata_kept", bus.d_rdata, {16{16'h5AC3}});

        // Tie after reset: D, I, then D, I again
        do_reset();
        mem_lat = 2;
        exp_d_rd(32'h0000_0200, {8{32'h11112222}});
        exp_i(32'h0000_0100, {8{32'h33334444}});
        i_addr_v = 32'h0000_0100; d_addr_v = 32'h0000_0200;
        i_read_v = 1'b1; d_read_v = 1'b1;
        run_done(60);
        exp_d_rd(32'h0000_0240, {8{32'h55556666}});
        exp_i(32'h0000_0140, {8{32'h77778888}});
        i_addr_v = 32'h0000_0140; d_addr_v = 32'h0000_0240;
        i_read_v = 1'b1; d_read_v = 1'b1;
        run_done(60);
        check("tie_i_rdata", bus.i_rdata, model_i);

        // Illegal read+write: treated as a write
        mem_lat = 1;
        exp_d_wr(32'h0000_0300, {8{32'hCAFEF00D}});
        d_addr_v = 32'h0000_0300; d_wdata_v = {8{32'hCAFEF00D}};
        d_read_v = 1'b1; d_write_v = 1'b1;
        run_done(50);

        // Reset during BUSY_D, then a late m_resp must be ignored
        mem_en = 1'b0;
        d_addr_v = 32'h0000_0500; d_wdata_v = {8{32'h0BADF00D}}; d_write_v = 1'b1;
        cnt = 0;
        while (!bus.m_write && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_mid_m_write", LINE_W'(bus.m_write), 1);
        @(negedge clk);
        rst = 1'b0;
        d_write_v = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_i = '0;
        model_d = '0;
        check_zero("rst_mid");
        spur_resp = 1'b1;
        @(negedge clk);
        spur_resp = 1'b0;
        repeat (3) @(negedge clk);
        mem_en = 1'b1;
        mem_lat = 2;
        exp_i(32'h0000_0700, {8{32'h0F0F1E1E}});
        i_addr_v = 32'h0000_0700; i_read_v = 1'b1;
        run_done(50);

        // Early m_resp coincident with the first strobe cycle
        mem_lat = 1;
        exp_i(32'h0000_0800, {8{32'h89ABCDEF}});
        i_addr_v = 32'h0000_0800; i_read_v = 1'b1;
        @(negedge clk);
        check("early_resp_n1", LINE_W'(bus.i_resp), 0);
        check("early_m_read", LINE_W'(bus.m_read), 1);
        @(negedge clk);
        check("early_resp_n2", LINE_W'(bus.i_resp), 1);
        i_read_v = 1'b0;
        spur_resp = 1'b1;
        @(negedge clk);
        spur_resp = 1'b0;
        check("early_resp_n3", LINE_W'(bus.i_resp), 0);
        @(negedge clk);
        spur_resp = 1'b1;
        @(negedge clk);
        spur_resp = 1'b0;
        repeat (4) @(negedge clk);
        check("early_m_idle", LINE_W'(bus.m_read | bus.m_write), 0);

        check("mem_q_empty", LINE_W'(mem_q.size()), 0);
        check("resp_q_empty", LINE_W'(resp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cache_line_arbiter.md
# cache_line_arbiter

- Shares the single cacheline-wide physical memory port between the instruction-side and data-side caches that feed the pipelined datapath.
- Accepts at most one outstanding line transaction at a time and latches the winner's address and write data.
- Drives the memory port with registered signals and returns the line and a one-cycle response to the granted requester.
- Simultaneous requests are resolved round-robin, so neither fetch nor load/store traffic starves.

## Interface

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, line address width; low log2(LINE_W/8) bits are passed through unchanged.

Ports:
- clk  input  1  the block's single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (asserted when 0).
- i_read  input  1  instruction-side line read request; level, held until i_resp.
- i_addr  input  ADDR_W  instruction-side line address.
- i_rdata  output  LINE_W  returned line for instruction side.
- i_resp  output  1  one-cycle completion pulse to instruction side.
- d_read  input  1  data-side line read request; level, held until d_resp.
- d_write  input  1  data-side line write-back request; level, held until d_resp.
- d_addr  input  ADDR_W  data-side line address.
- d_wdata  input  LINE_W  data-side write-back line.
- d_rdata  output  LINE_W  returned line for data side.
- d_resp  output  1  one-cycle completion pulse to data side.
- m_read  output  1  memory read strobe, held until m_resp.
- m_write  output  1  memory write strobe, held until m_resp.
- m_addr  output  ADDR_W  memory line address.
- m_wdata  output  LINE_W  memory write line.
- m_rdata  input  LINE_W  memory read line, valid with m_resp.
- m_resp  input  1  memory completion, one cycle.

## Operation

States: IDLE, BUSY_I, BUSY_D, DONE.

- **IDLE**
  - Samples requests. The data-side request is d_req = d_read | d_write.
  - Only i_read set: latch i_addr and go to BUSY_I.
  - Only d_req set: latch d_addr, d_wdata and op, then go to BUSY_D.
  - Both set: grant the side opposite to last_grant; update last_grant to the winner.
  - m_resp while IDLE is ignored.
- **BUSY_I**
  - m_read=1; m_addr = latched address.
  - On m_resp: capture m_rdata into the I-line register and go to DONE.
- **BUSY_D**
  - m_read=1 for a read, m_write=1 for a write; m_addr/m_wdata = latched values.
  - On m_resp: capture m_rdata on reads only (the D-line register is unchanged on writes) and go to DONE.
- **DONE**
  - The granted side's resp=1 for exactly one cycle; m_read=m_write=0.
  - Unconditionally go to IDLE. This gives the requester one edge to drop its request before re-arbitration.
- **Request handling**
  - d_read and d_write both high is illegal; d_write takes precedence.
  - Request inputs are not re-sampled outside IDLE. Address or data changes mid-transaction have no effect.
- **last_grant**
  - Resets to I, so the first tie grants D.
- **Output registers**
  - i_rdata and d_rdata hold their last captured line until overwritten.
- **Reset values (rst=0 at an edge)**
  - State IDLE and last_grant=I.
  - i_resp=d_resp=m_read=m_write=0.
  - m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0.
- **Reset mid-transaction**
  - The transaction is abandoned; no resp is issued.
  - A subsequent m_resp in IDLE is ignored.

## Timing

- Request seen in IDLE at edge N: m_read/m_write high from N+1.
- m_resp sampled at edge K: resp high during cycle K+1 (DONE), with rdata valid in the same cycle.
- Block returns to IDLE at K+2; the earliest next grant is at K+2, with memory strobes from K+3.
- Overhead: 2 cycles before memory plus 1 turnaround; the memory port is idle for at least 2 cycles between transactions.
- m_resp in the same cycle the strobe first rises is legal and completes immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Single I read:** i_read=1, i_addr=0x0000_0060; memory answers m_resp at 3rd strobe cycle with m_rdata=0xA5…A5. Required:
  - m_read high for 3 cycles with m_addr=0x60.
  - i_resp one cycle with i_rdata=0xA5…A5.
  - d_resp stays 0.
- **D write-back:** d_write=1, d_addr=0x1000_0020, d_wdata=0x1234…; m_resp after 1 cycle. Required:
  - m_write=1 and m_read=0; m_wdata matches.
  - d_resp pulses once.
  - d_rdata unchanged from its prior value.
- **Tie after reset:** i_read and d_read both asserted and held. Required:
  - Order is D then I.
  - Then with both re-asserted after completion, order D→I→D→I (strict alternation).
- **Illegal op:** d_read=d_write=1. Required:
  - Memory sees m_write=1, m_read=0.
  - d_resp pulses once.
- **Reset mid-BUSY_D:** rst=0 for one edge while m_write=1. Required:
  - Next cycle all outputs 0.
  - A late m_resp produces no i_resp/d_resp.
  - A fresh i_read is granted normally.
- **Early m_resp:** m_resp coincident with first m_read cycle. Required:
  - i_resp is exactly 2 cycles after the request edge.
  - m_resp pulses arriving in IDLE or DONE produce no resp.
